// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants for the BRAM port arbiter: read-owner encoding and the
// default SPI address window.
package bram_port_arbiter_pkg;

  localparam logic [1:0] c_own_none = 2'd0;
  localparam logic [1:0] c_own_spi  = 2'd1;
  localparam logic [1:0] c_own_host = 2'd2;

  localparam logic [7:0] c_spi_window_default = 8'h00;

  // True when the top byte of an SPI byte address selects this BRAM.
  function automatic logic spi_in_window(input logic [31:0] addr, input logic [7:0] window);
    return addr[31:24] == window;
  endfunction

endpackage

// File: rtl/bram_port_arbiter.sv
// Single-port BRAM arbiter between a non-stallable SPI slave and a host.
//
// The SPI side gets a 1-deep pending slot that always issues on the cycle
// after its strobe, so it can never be lost. The host waits while an SPI op
// is pending, and also while an in-window SPI strobe is arriving, because
// that strobe is guaranteed to own the port on the next cycle. mem_rdata is
// steered by a 1-stage owner register and forwarded straight to the owner in
// the cycle it returns, then held in a capture register.
//
// owner_q    | meaning
// c_own_none | no read issued last cycle
// c_own_spi  | last cycle issued an SPI read, mem_rdata belongs to SPI
// c_own_host | last cycle issued a host read, mem_rdata belongs to host
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned c_addr_bits  = 4,
  parameter int unsigned c_data_width = 8,
  parameter logic [7:0]  c_spi_window = c_spi_window_default
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    spi_wr,
  input  logic                    spi_rd,
  input  logic [31:0]             spi_addr,
  input  logic [c_data_width-1:0] spi_wdata,
  output logic [c_data_width-1:0] spi_rdata,
  input  logic                    host_req,
  input  logic                    host_we,
  input  logic [c_addr_bits-1:0]  host_addr,
  input  logic [c_data_width-1:0] host_wdata,
  output logic                    host_ack,
  output logic [c_data_width-1:0] host_rdata,
  output logic                    host_rvalid,
  output logic [c_addr_bits-1:0]  mem_addr,
  output logic                    mem_we,
  output logic [c_data_width-1:0] mem_wdata,
  input  logic [c_data_width-1:0] mem_rdata,
  output logic                    err_collide
);

  logic                    pend_valid;
  logic                    pend_we;
  logic [c_addr_bits-1:0]  pend_addr;
  logic [c_data_width-1:0] pend_data;

  logic                    spi_hit;
  logic                    issue_spi;
  logic                    issue_host;
  logic                    issue;
  logic                    sel_we;
  logic [c_addr_bits-1:0]  sel_addr;
  logic [c_data_width-1:0] sel_data;

  logic [c_addr_bits-1:0]  addr_q;
  logic [c_data_width-1:0] wdata_q;
  logic [1:0]              owner_q;
  logic [c_data_width-1:0] spi_rdata_q;
  logic [c_data_width-1:0] host_rdata_q;
  logic                    err_q;

  // Only the window byte and the low c_addr_bits of spi_addr matter; the
  // bits in between are deliberately dropped.
  logic spi_addr_unused;
  assign spi_addr_unused = ^spi_addr;

  assign spi_hit = (spi_wr | spi_rd) & spi_in_window(spi_addr, c_spi_window);

  // Arbitration: pending SPI first, then host unless SPI is about to claim the port.
  always_comb begin
    issue_spi  = pend_valid;
    issue_host = resetn & host_req & ~pend_valid & ~spi_hit;
    issue      = issue_spi | issue_host;
    if (issue_spi) begin
      sel_we   = pend_we;
      sel_addr = pend_addr;
      sel_data = pend_data;
    end else begin
      sel_we   = host_we;
      sel_addr = host_addr;
      sel_data = host_wdata;
    end
  end

  // BRAM drive: idle cycles keep the last address and never write.
  always_comb begin
    mem_we    = issue & sel_we;
    mem_addr  = issue ? sel_addr : addr_q;
    mem_wdata = (issue & sel_we) ? sel_data : wdata_q;
  end

  assign host_ack = issue_host;

  // Pending SPI slot: filled by any in-window strobe, drained the next cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_valid <= 1'b0;
      pend_we    <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else if (spi_hit) begin
      pend_valid <= 1'b1;
      pend_we    <= spi_wr;
      pend_addr  <= spi_addr[c_addr_bits-1:0];
      pend_data  <= spi_wdata;
    end else begin
      pend_valid <= 1'b0;
    end
  end

  // Remember the last issued address and write data for idle-cycle hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (issue) begin
      addr_q <= sel_addr;
      if (sel_we) wdata_q <= sel_data;
    end
  end

  // Owner of the read data returning next cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q <= c_own_none;
    end else if (issue && !sel_we) begin
      owner_q <= issue_spi ? c_own_spi : c_own_host;
    end else begin
      owner_q <= c_own_none;
    end
  end

  // Capture returning read data so each side keeps its last result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      spi_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      if (owner_q == c_own_spi)  spi_rdata_q  <= mem_rdata;
      if (owner_q == c_own_host) host_rdata_q <= mem_rdata;
    end
  end

  // Sticky collision flag; a colliding strobe is still serviced as a write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else if (spi_wr && spi_rd) begin
      err_q <= 1'b1;
    end
  end

  assign spi_rdata   = (owner_q == c_own_spi)  ? mem_rdata : spi_rdata_q;
  assign host_rdata  = (owner_q == c_own_host) ? mem_rdata : host_rdata_q;
  assign host_rvalid = (owner_q == c_own_host);
  assign err_collide = err_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed scenarios followed by a randomized
// run compared against a transaction-level reference model.
module tb_bram_port_arbiter;

  logic        clk;
  logic        resetn;
  logic        spi_wr, spi_rd;
  logic [31:0] spi_addr;
  logic [7:0]  spi_wdata, spi_rdata;
  logic        host_req, host_we, host_ack, host_rvalid;
  logic [3:0]  host_addr;
  logic [7:0]  host_wdata, host_rdata;
  logic [3:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        err_collide;

  bram_port_arbiter dut (
    .clk(clk), .resetn(resetn),
    .spi_wr(spi_wr), .spi_rd(spi_rd), .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .err_collide(err_collide)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port BRAM with 1-cycle read latency.
  logic [7:0] bram [16];
  logic       bram_clr;
  always @(posedge clk) begin
    if (bram_clr) begin
      for (int i = 0; i < 16; i++) bram[i] <= 8'h00;
    end else if (mem_we) begin
      bram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= bram[mem_addr];
  end

  int n_checks;
  int n_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Reference model state: a queue of accepted SPI ops, a queue of read
  // returns with their due cycle, and a shadow of the BRAM contents.
  typedef struct { logic we; logic [3:0] addr; logic [7:0] data; } op_t;
  typedef struct { int due; bit to_host; logic [7:0] data; } ret_t;
  op_t        spi_q[$];
  ret_t       ret_q[$];
  logic [7:0] shadow [16];
  logic [3:0] m_last_addr;
  logic [7:0] m_spi_rdata;
  logic       m_err;
  op_t        op;
  ret_t       rt;
  logic       hit, have_issue, from_host, e_ack, e_we, e_rv, ack_prev;
  logic [3:0] e_addr;
  logic [7:0] e_rdata;
  int         r;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    bram_clr = 1'b1;
    resetn   = 1'b0;
    // Live requests and a collision while held in reset must be ignored.
    spi_wr = 1'b1; spi_rd = 1'b1; spi_addr = 32'h0; spi_wdata = 8'h11;
    host_req = 1'b1; host_we = 1'b1; host_addr = 4'hA; host_wdata = 8'hFF;
    settle();
    chk("rst_spi_rdata", spi_rdata, 0);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_host_ack", host_ack, 0);
    chk("rst_host_rvalid", host_rvalid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    next_cyc();
    settle();
    chk("rst_err_collide", err_collide, 0);
    chk("rst_mem_we_2", mem_we, 0);
    next_cyc();
    spi_wr = 1'b0; spi_rd = 1'b0; host_req = 1'b0;
    bram_clr = 1'b0;
    resetn = 1'b1;
    settle();

    // SPI write lands on the BRAM exactly one cycle after the strobe.
    next_cyc();
    spi_wr = 1'b1; spi_addr = 32'h0000_0003; spi_wdata = 8'h5A;
    settle();
    chk("spiwr_strobe_we", mem_we, 0);
    next_cyc();
    spi_wr = 1'b0;
    settle();
    chk("spiwr_we", mem_we, 1);
    chk("spiwr_addr", mem_addr, 3);
    chk("spiwr_wdata", mem_wdata, 8'h5A);
    chk("spiwr_no_ack", host_ack, 0);
    next_cyc();
    settle();
    chk("idle_we", mem_we, 0);
    chk("idle_addr_hold", mem_addr, 3);
    chk("spiwr_bram", bram[3], 8'h5A);

    // SPI read: strobe, issue, capture; result held afterwards.
    next_cyc();
    spi_rd = 1'b1; spi_addr = 32'h0000_0003;
    settle();
    next_cyc();
    spi_rd = 1'b0;
    settle();
    chk("spird_issue_we", mem_we, 0);
    chk("spird_issue_addr", mem_addr, 3);
    next_cyc();
    settle();
    next_cyc();
    settle();
    chk("spird_rdata", spi_rdata, 8'h5A);
    next_cyc();
    next_cyc();
    settle();
    chk("spird_rdata_held", spi_rdata, 8'h5A);

    // Strobe outside the window is dropped.
    next_cyc();
    spi_wr = 1'b1; spi_addr = 32'h0100_0003; spi_wdata = 8'hEE;
    settle();
    next_cyc();
    spi_wr = 1'b0;
    settle();
    chk("oow_we", mem_we, 0);
    next_cyc();
    settle();
    chk("oow_spi_rdata", spi_rdata, 8'h5A);
    chk("oow_bram", bram[3], 8'h5A);

    // Back-to-back host writes with the request held.
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      host_req = 1'b1; host_we = 1'b1; host_addr = 4'(i); host_wdata = 8'(8'h10 + i);
      settle();
      chk("b2b_ack", host_ack, 1);
      chk("b2b_we", mem_we, 1);
      chk("b2b_addr", mem_addr, i);
      chk("b2b_wdata", mem_wdata, 8'h10 + i);
    end
    next_cyc();
    host_req = 1'b0;
    settle();
    chk("b2b_ack_end", host_ack, 0);
    chk("b2b_spi_rdata_kept", spi_rdata, 8'h5A);
    for (int i = 0; i < 4; i++) chk("b2b_bram", bram[i], 8'h10 + i);

    // In-window SPI write with junk in the ignored middle address bits.
    next_cyc();
    spi_wr = 1'b1; spi_addr = 32'h00AB_CDE5; spi_wdata = 8'hC3;
    settle();
    next_cyc();
    spi_wr = 1'b0;
    settle();
    chk("trunc_addr", mem_addr, 5);
    chk("trunc_we", mem_we, 1);

    // Contention: host read and SPI write arrive together.
    next_cyc();
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'd5;
    spi_wr = 1'b1; spi_addr = 32'h0000_0007; spi_wdata = 8'h77;
    settle();
    chk("cont_strobe_ack", host_ack, 0);
    next_cyc();
    spi_wr = 1'b0;
    settle();
    chk("cont_spi_we", mem_we, 1);
    chk("cont_spi_addr", mem_addr, 7);
    chk("cont_spi_no_ack", host_ack, 0);
    next_cyc();
    settle();
    chk("cont_host_ack", host_ack, 1);
    chk("cont_host_addr", mem_addr, 5);
    chk("cont_host_we", mem_we, 0);
    next_cyc();
    host_req = 1'b0;
    settle();
    chk("cont_rvalid", host_rvalid, 1);
    chk("cont_rdata", host_rdata, 8'hC3);
    next_cyc();
    settle();
    chk("cont_rvalid_pulse", host_rvalid, 0);

    // Collision is serviced as a write and latches the error flag.
    next_cyc();
    spi_wr = 1'b1; spi_rd = 1'b1; spi_addr = 32'h0000_0009; spi_wdata = 8'h99;
    settle();
    next_cyc();
    spi_wr = 1'b0; spi_rd = 1'b0;
    settle();
    chk("coll_we", mem_we, 1);
    chk("coll_wdata", mem_wdata, 8'h99);
    chk("coll_err", err_collide, 1);
    next_cyc();
    next_cyc();
    settle();
    chk("coll_err_sticky", err_collide, 1);
    chk("coll_bram", bram[9], 8'h99);
    chk("coll_spi_rdata", spi_rdata, 8'h5A);

    // Reset in the middle of a host read drops the return.
    next_cyc();
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'd2;
    settle();
    chk("rstmid_ack", host_ack, 1);
    next_cyc();
    host_req = 1'b0;
    resetn = 1'b0;
    settle();
    chk("rstmid_rvalid", host_rvalid, 0);
    chk("rstmid_spi_rdata", spi_rdata, 0);
    chk("rstmid_host_rdata", host_rdata, 0);
    chk("rstmid_mem_addr", mem_addr, 0);
    chk("rstmid_mem_wdata", mem_wdata, 0);
    chk("rstmid_err", err_collide, 0);
    next_cyc();
    resetn = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 4'd6; host_wdata = 8'h66;
    settle();
    chk("rel_ack_first_cycle", host_ack, 1);
    chk("rel_rvalid", host_rvalid, 0);
    next_cyc();
    host_req = 1'b0;
    settle();
    chk("rel_rvalid_2", host_rvalid, 0);

    // Randomized traffic against the reference model, from a clean reset.
    next_cyc();
    resetn = 1'b0;
    bram_clr = 1'b1;
    next_cyc();
    resetn = 1'b1;
    bram_clr = 1'b0;
    for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
    spi_q.delete();
    ret_q.delete();
    m_last_addr = 4'd0;
    m_spi_rdata = 8'h00;
    m_err = 1'b0;
    ack_prev = 1'b0;
    for (int c = 0; c < 400; c++) begin
      next_cyc();
      if (host_req && ack_prev) begin
        if ($urandom_range(0, 1) == 1) begin
          host_we = 1'($urandom_range(0, 1)); host_addr = 4'($urandom_range(0, 15));
          host_wdata = 8'($urandom_range(0, 255));
        end else begin
          host_req = 1'b0;
        end
      end else if (!host_req && $urandom_range(0, 2) == 0) begin
        host_req = 1'b1;
        host_we = 1'($urandom_range(0, 1)); host_addr = 4'($urandom_range(0, 15));
        host_wdata = 8'($urandom_range(0, 255));
      end
      r = int'($urandom_range(0, 15));
      spi_wr = (r < 3) || (r == 6);
      spi_rd = (r >= 3 && r < 7);
      spi_addr = {($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 24'($urandom)};
      spi_wdata = 8'($urandom_range(0, 255));
      settle();

      hit = (spi_wr || spi_rd) && (spi_addr[31:24] == 8'h00);
      have_issue = 1'b0; from_host = 1'b0; e_ack = 1'b0; e_we = 1'b0; e_rv = 1'b0;
      e_addr = m_last_addr; e_rdata = 8'h00;
      if (spi_q.size() > 0) begin
        op = spi_q.pop_front();
        have_issue = 1'b1;
      end else if (host_req && !hit) begin
        op = '{host_we, host_addr, host_wdata};
        have_issue = 1'b1; from_host = 1'b1; e_ack = 1'b1;
      end
      if (have_issue) begin
        e_we = op.we;
        e_addr = op.addr;
        if (op.we) shadow[op.addr] = op.data;
        else ret_q.push_back('{c + 1, from_host, shadow[op.addr]});
      end
      if (ret_q.size() > 0 && ret_q[0].due == c) begin
        rt = ret_q.pop_front();
        if (rt.to_host) begin
          e_rv = 1'b1; e_rdata = rt.data;
        end else begin
          m_spi_rdata = rt.data;
        end
      end

      chk("rnd_mem_we", mem_we, e_we);
      chk("rnd_mem_addr", mem_addr, e_addr);
      if (e_we) chk("rnd_mem_wdata", mem_wdata, op.data);
      chk("rnd_host_ack", host_ack, e_ack);
      chk("rnd_host_rvalid", host_rvalid, e_rv);
      if (e_rv) chk("rnd_host_rdata", host_rdata, e_rdata);
      chk("rnd_spi_rdata", spi_rdata, m_spi_rdata);
      chk("rnd_err_collide", err_collide, m_err);

      if (hit) spi_q.push_back('{spi_wr, spi_addr[3:0], spi_wdata});
      if (spi_wr && spi_rd) m_err = 1'b1;
      m_last_addr = e_addr;
      ack_prev = e_ack;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
